// File: rtl/click_decoder.sv
// Click-sequence decoder: groups debounced presses into single/double/triple clicks.
// Define CLICK_TRIPLE_EN to enable triple-click detection (max count 3 instead of 2).
module click_decoder #(
    parameter logic [31:0] WINDOW_CYCLES = 32'd25000000
) (
    input  logic clk,
    input  logic reset,
    input  logic press,
    output logic single_click = 1'b0,
    output logic double_click = 1'b0,
    output logic triple_click = 1'b0,
    output logic busy = 1'b0
);

`ifdef CLICK_TRIPLE_EN
    localparam logic [1:0] MAX_COUNT = 2'd3;
`else
    localparam logic [1:0] MAX_COUNT = 2'd2;
`endif

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t      state = IDLE;
    state_t      state_n;
    logic [31:0] timer = '0;
    logic [31:0] timer_n;
    logic [1:0]  count = '0;
    logic [1:0]  count_n;
    logic        emit;
    logic [1:0]  emit_count;
    logic        single_n;
    logic        double_n;
    logic        triple_n;

    always_comb begin
        state_n    = state;
        timer_n    = timer;
        count_n    = count;
        emit       = 1'b0;
        emit_count = 2'd0;
        unique case (state)
            IDLE: begin
                if (press) begin
                    count_n = 2'd1;
                    timer_n = WINDOW_CYCLES;
                    state_n = COLLECT;
                end
            end
            COLLECT: begin
                // A press always beats the timeout, even when timer == 1.
                if (press) begin
                    if (count == MAX_COUNT - 2'd1) begin
                        emit       = 1'b1;
                        emit_count = MAX_COUNT;
                        count_n    = 2'd0;
                        timer_n    = '0;
                        state_n    = IDLE;
                    end else begin
                        count_n = count + 2'd1;
                        timer_n = WINDOW_CYCLES;
                    end
                end else if (timer > 32'd1) begin
                    timer_n = timer - 32'd1;
                end else begin
                    emit       = 1'b1;
                    emit_count = count;
                    count_n    = 2'd0;
                    timer_n    = '0;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        single_n = emit && (emit_count == 2'd1);
        double_n = emit && (emit_count == 2'd2);
`ifdef CLICK_TRIPLE_EN
        triple_n = emit && (emit_count == 2'd3);
`else
        triple_n = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            count        <= '0;
            single_click <= 1'b0;
            double_click <= 1'b0;
            triple_click <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            timer        <= timer_n;
            count        <= count_n;
            single_click <= single_n;
            double_click <= double_n;
            triple_click <= triple_n;
            busy         <= (state_n == COLLECT);
        end
    end

endmodule
